// File: rtl/lite16_pkg.sv
// LITE-16 shared definitions: opcodes, control-unit state encoding, ALU
// function codes and the decoded-instruction bundle.
package lite16_pkg;

  // Opcode field IR[15:12]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_JEQ = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-unit sequencing states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // ALU function select codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  // Everything the sequencer needs to know about the instruction in the IR
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       writes_rd;
    logic       is_cmp;
    logic       is_jeq;
    logic       is_jmp;
    logic       is_hlt;
    logic       is_illegal;
  } dec_t;

  // Immediate is the low IR byte, zero-extended to the datapath width
  function automatic logic [15:0] zext_imm(input logic [7:0] imm8);
    return {8'h00, imm8};
  endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Purely combinational opcode decoder for the LITE-16 control unit.
module instr_decoder
  import lite16_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [3:0] op_s;

  assign op_s = ir[15:12];

  // Map the opcode to ALU select and sequencing qualifiers
  always_comb begin
    dec = '0;
    dec.alu_op = ALU_ADD;
    case (op_s)
      OP_NOP: dec.alu_op = ALU_ADD;
      OP_ADD: begin dec.alu_op = ALU_ADD; dec.writes_rd = 1'b1; end
      OP_SUB: begin dec.alu_op = ALU_SUB; dec.writes_rd = 1'b1; end
      OP_AND: begin dec.alu_op = ALU_AND; dec.writes_rd = 1'b1; end
      OP_OR:  begin dec.alu_op = ALU_OR;  dec.writes_rd = 1'b1; end
      OP_XOR: begin dec.alu_op = ALU_XOR; dec.writes_rd = 1'b1; end
      OP_LDI: begin
        dec.alu_op      = ALU_PASSB;
        dec.alu_src_imm = 1'b1;
        dec.writes_rd   = 1'b1;
      end
      OP_CMP: begin dec.alu_op = ALU_SUB; dec.is_cmp = 1'b1; end
      OP_JEQ: dec.is_jeq = 1'b1;
      OP_JMP: dec.is_jmp = 1'b1;
      OP_HLT: dec.is_hlt = 1'b1;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: dec.is_illegal = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// LITE-16 multi-cycle control unit: instruction register, compare flag,
// FETCH/DECODE/EXEC/WB sequencer and registered regfile/ALU/PC controls.
module control_unit
  import lite16_pkg::*;
#(
  parameter state_t RESET_STATE = ST_FETCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  rd_addr,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  output logic        reg_we,
  output logic        pc_en,
  output logic        jmp,
  output logic        cmp,
  output logic        halted,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        flag_q, flag_d;
  logic        illegal_q, illegal_d;
  logic        halted_q, halted_d;
  logic        reg_we_q, reg_we_d;
  logic        pc_en_q, pc_en_d;
  logic        jmp_q, jmp_d;
  logic        cmp_q, cmp_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic        wb_next_s;
  dec_t        dec_s;

  instr_decoder u_dec (
    .ir  (ir_q),
    .dec (dec_s)
  );

  // Register-address and immediate fields come straight from the IR flops
  assign rd_addr     = ir_q[11:8];
  assign rs_addr     = ir_q[7:4];
  assign rt_addr     = ir_q[3:0];
  assign imm         = zext_imm(ir_q[7:0]);
  assign alu_op      = alu_op_q;
  assign alu_src_imm = alu_src_imm_q;
  assign reg_we      = reg_we_q;
  assign pc_en       = pc_en_q;
  assign jmp         = jmp_q;
  assign cmp         = cmp_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

  // Next-state, IR/flag update and next-cycle strobes (outputs are registered,
  // so every strobe is derived from the state being entered)
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    flag_d        = flag_q;
    alu_op_d      = dec_s.alu_op;
    alu_src_imm_d = dec_s.alu_src_imm;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
        ir_d    = instruction;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WB;
        if (dec_s.is_cmp) begin
          flag_d = (rs_data == rt_data);
        end else begin
          flag_d = flag_q;
        end
      end
      ST_WB: begin
        if (dec_s.is_hlt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    wb_next_s = (state_d == ST_WB);
    reg_we_d  = wb_next_s && dec_s.writes_rd;
    pc_en_d   = wb_next_s;
    jmp_d     = wb_next_s && (dec_s.is_jeq || dec_s.is_jmp);
    if (wb_next_s && dec_s.is_jmp) begin
      cmp_d = 1'b1;
    end else begin
      cmp_d = flag_d;
    end
    halted_d  = (state_d == ST_HALT);
    illegal_d = illegal_q || ((state_d == ST_EXEC) && dec_s.is_illegal);
  end

  // Sequencer state, IR, flag and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RESET_STATE;
      ir_q          <= 16'h0000;
      flag_q        <= 1'b0;
      illegal_q     <= 1'b0;
      halted_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      pc_en_q       <= 1'b0;
      jmp_q         <= 1'b0;
      cmp_q         <= 1'b0;
      alu_op_q      <= ALU_ADD;
      alu_src_imm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      flag_q        <= flag_d;
      illegal_q     <= illegal_d;
      halted_q      <= halted_d;
      reg_we_q      <= reg_we_d;
      pc_en_q       <= pc_en_d;
      jmp_q         <= jmp_d;
      cmp_q         <= cmp_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
    end
  end

endmodule
